// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator with registered ROM address generation, runtime
// reconfiguration and a linear frequency sweep that advances once per wrap.
module dds_phase_accumulator #(
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ACC_WIDTH-1:0]  cfg_ftw,
    input  logic [ADDR_WIDTH-1:0] cfg_pow,
    input  logic                  cfg_phase_clr,
    input  logic                  sweep_start,
    input  logic [ACC_WIDTH-1:0]  sweep_step,
    input  logic [ACC_WIDTH-1:0]  sweep_stop,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    output logic                  wrap,
    output logic                  sweep_busy,
    output logic                  sweep_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIXED = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    logic [ACC_WIDTH-1:0]  acc_q,  acc_d;
    logic [ACC_WIDTH-1:0]  ftw_q,  ftw_d;
    logic [ADDR_WIDTH-1:0] pow_q,  pow_d;
    logic [ACC_WIDTH-1:0]  step_q, step_d;
    logic [ACC_WIDTH-1:0]  stop_q, stop_d;
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  wrap_q, wrap_d;
    logic                  done_q, done_d;

    logic [ACC_WIDTH:0]    acc_sum_s;
    logic [ACC_WIDTH:0]    sweep_sum_s;
    logic [ADDR_WIDTH-1:0] phase_s;
    logic                  carry_s;
    logic                  cfg_accept_s;

    assign acc_sum_s    = {1'b0, acc_q} + {1'b0, ftw_q};
    assign sweep_sum_s  = {1'b0, ftw_q} + {1'b0, step_q};
    assign phase_s      = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];
    assign carry_s      = en & acc_sum_s[ACC_WIDTH];
    assign cfg_ready    = (state_q != ST_SWEEP);
    assign sweep_busy   = (state_q == ST_SWEEP);
    assign cfg_accept_s = cfg_valid & cfg_ready;

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign wrap       = wrap_q;
    assign sweep_done = done_q;

    // Next-state: accumulation, config acceptance and sweep control.
    always_comb begin
        acc_d        = acc_q;
        ftw_d        = ftw_q;
        pow_d        = pow_q;
        step_d       = step_q;
        stop_d       = stop_q;
        state_d      = state_q;
        addr_d       = addr_q;
        addr_valid_d = en;
        wrap_d       = 1'b0;
        done_d       = 1'b0;

        if (en) begin
            addr_d = phase_s + pow_q;
            acc_d  = acc_sum_s[ACC_WIDTH-1:0];
            wrap_d = acc_sum_s[ACC_WIDTH];
        end else begin
            addr_d = addr_q;
        end

        // A config accept pre-empts any sweep request on the same edge.
        if (cfg_accept_s) begin
            ftw_d   = cfg_ftw;
            pow_d   = cfg_pow;
            state_d = ST_FIXED;
            if (cfg_phase_clr) begin
                acc_d  = {ACC_WIDTH{1'b0}};
                wrap_d = 1'b0;
            end else begin
                acc_d  = acc_d;
            end
        end else begin
            case (state_q)
                ST_FIXED: begin
                    if (sweep_start) begin
                        step_d = sweep_step;
                        stop_d = sweep_stop;
                        if (sweep_stop <= ftw_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_SWEEP;
                        end
                    end else begin
                        state_d = ST_FIXED;
                    end
                end
                ST_SWEEP: begin
                    if (carry_s) begin
                        if (sweep_sum_s >= {1'b0, stop_q}) begin
                            ftw_d   = stop_q;
                            done_d  = 1'b1;
                            state_d = ST_FIXED;
                        end else begin
                            ftw_d = sweep_sum_s[ACC_WIDTH-1:0];
                        end
                    end else begin
                        state_d = ST_SWEEP;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= {ACC_WIDTH{1'b0}};
            ftw_q        <= {ACC_WIDTH{1'b0}};
            pow_q        <= {ADDR_WIDTH{1'b0}};
            step_q       <= {ACC_WIDTH{1'b0}};
            stop_q       <= {ACC_WIDTH{1'b0}};
            state_q      <= ST_IDLE;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            pow_q        <= pow_d;
            step_q       <= step_d;
            stop_q       <= stop_d;
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            wrap_q       <= wrap_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed and randomized checks of dds_phase_accumulator against an
// arithmetic reference model of the phase/sweep behaviour.
module tb_dds_phase_accumulator;

    localparam int AW = 32;
    localparam int DW = 4;
    localparam longint unsigned MOD  = 64'h1_0000_0000;
    localparam longint unsigned AMOD = 64'd16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_ftw;
    logic [DW-1:0] cfg_pow;
    logic          cfg_phase_clr;
    logic          sweep_start;
    logic [AW-1:0] sweep_step;
    logic [AW-1:0] sweep_stop;
    logic [DW-1:0] addr;
    logic          addr_valid;
    logic          wrap;
    logic          sweep_busy;
    logic          sweep_done;

    int tests_run    = 0;
    int tests_failed = 0;

    longint unsigned m_acc, m_ftw, m_pow, m_step, m_stop;
    bit              m_configured, m_sweeping;
    longint unsigned e_addr;
    bit              e_valid, e_wrap, e_done;

    always #5 clk = ~clk;

    dds_phase_accumulator #(.ACC_WIDTH(AW), .ADDR_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ftw(cfg_ftw), .cfg_pow(cfg_pow), .cfg_phase_clr(cfg_phase_clr),
        .sweep_start(sweep_start), .sweep_step(sweep_step), .sweep_stop(sweep_stop),
        .addr(addr), .addr_valid(addr_valid), .wrap(wrap),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_pow = 0; m_step = 0; m_stop = 0;
        m_configured = 1'b0; m_sweeping = 1'b0;
        e_addr = 0; e_valid = 1'b0; e_wrap = 1'b0; e_done = 1'b0;
    endtask

    // One rising edge of the behavioural model, using the current input values.
    task automatic model_edge();
        longint unsigned sum, nacc, nftw;
        bit carry;
        nacc  = m_acc;
        nftw  = m_ftw;
        carry = 1'b0;
        e_valid = en;
        e_wrap  = 1'b0;
        e_done  = 1'b0;
        if (en) begin
            e_addr = ((m_acc / (MOD / AMOD)) + m_pow) % AMOD;
            sum    = m_acc + m_ftw;
            carry  = (sum >= MOD);
            e_wrap = carry;
            nacc   = sum % MOD;
        end
        if (cfg_valid && !m_sweeping) begin
            nftw  = cfg_ftw;
            m_pow = cfg_pow;
            m_configured = 1'b1;
            if (cfg_phase_clr) begin
                nacc   = 0;
                e_wrap = 1'b0;
            end
        end else if (m_sweeping) begin
            if (carry) begin
                sum = m_ftw + m_step;
                if (sum >= m_stop) begin
                    nftw = m_stop;
                    e_done = 1'b1;
                    m_sweeping = 1'b0;
                end else begin
                    nftw = sum;
                end
            end
        end else if (m_configured && sweep_start) begin
            m_step = sweep_step;
            m_stop = sweep_stop;
            if (sweep_stop <= m_ftw) e_done = 1'b1;
            else m_sweeping = 1'b1;
        end
        m_acc = nacc;
        m_ftw = nftw;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".addr"},       addr,       e_addr);
        chk({where, ".addr_valid"}, addr_valid, e_valid);
        chk({where, ".wrap"},       wrap,       e_wrap);
        chk({where, ".sweep_done"}, sweep_done, e_done);
        chk({where, ".sweep_busy"}, sweep_busy, m_sweeping);
        chk({where, ".cfg_ready"},  cfg_ready,  !m_sweeping);
    endtask

    task automatic tick(input string where);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(where);
    endtask

    task automatic configure(input logic [AW-1:0] ftw, input logic [DW-1:0] pow, input logic clr);
        cfg_valid = 1'b1; cfg_ftw = ftw; cfg_pow = pow; cfg_phase_clr = clr;
        tick("cfg");
        cfg_valid = 1'b0; cfg_phase_clr = 1'b0;
    endtask

    initial begin
        int done_count;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ftw = '0; cfg_pow = '0;
        cfg_phase_clr = 1'b0; sweep_start = 1'b0; sweep_step = '0; sweep_stop = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Sweep request before any config is ignored.
        sweep_start = 1'b1; sweep_step = 32'h1000_0000; sweep_stop = 32'hF000_0000;
        tick("idle_sweep");
        sweep_start = 1'b0;

        // Plain ramp 0..15,0 then offset ramp starting at 4.
        configure(32'h1000_0000, 4'd0, 1'b1);
        en = 1'b1;
        repeat (17) tick("ramp0");
        en = 1'b0;
        configure(32'h1000_0000, 4'd4, 1'b1);
        en = 1'b1;
        repeat (17) tick("ramp4");

        // Enable gating: 1,0,0,1.
        en = 1'b1; tick("gate1");
        en = 1'b0; tick("gate0a");
        tick("gate0b");
        en = 1'b1; tick("gate1b");

        // Config with phase clear while running.
        cfg_valid = 1'b1; cfg_ftw = 32'h2000_0000; cfg_pow = 4'd9; cfg_phase_clr = 1'b1;
        tick("clr_edge");
        cfg_valid = 1'b0; cfg_phase_clr = 1'b0;
        tick("clr_next");
        chk("clr_next_addr_const", addr, 64'd9);

        // Sweep 0x4000_0000 -> 0xA000_0000 in steps of 0x4000_0000.
        configure(32'h4000_0000, 4'd0, 1'b1);
        sweep_start = 1'b1; sweep_step = 32'h4000_0000; sweep_stop = 32'hA000_0000;
        tick("sweep_go");
        chk("sweep_entered", sweep_busy, 1'b1);
        done_count = 0;
        for (int i = 0; i < 64 && m_sweeping; i++) begin
            cfg_valid = (i % 2 == 0);
            cfg_ftw = 32'h0000_0001;
            sweep_start = 1'b1;
            tick("sweeping");
            if (sweep_done === 1'b1) done_count++;
        end
        cfg_valid = 1'b0; sweep_start = 1'b0;
        chk("sweep_finished", sweep_busy, 1'b0);
        chk("sweep_done_count", done_count, 1);
        repeat (6) tick("post_sweep");

        // Stop below the active FTW completes at once.
        sweep_start = 1'b1; sweep_step = 32'h0000_0001; sweep_stop = 32'h1000_0000;
        tick("sweep_imm");
        chk("sweep_imm_done", sweep_done, 1'b1);
        sweep_start = 1'b0;
        tick("sweep_imm2");

        // Asynchronous reset in the middle of a sweep.
        configure(32'h1000_0000, 4'd2, 1'b1);
        sweep_start = 1'b1; sweep_step = 32'h0100_0000; sweep_stop = 32'hF000_0000;
        tick("sweep2_go");
        sweep_start = 1'b0;
        repeat (20) tick("sweep2_run");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk); #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        repeat (20) tick("post_rst");

        // Randomized traffic.
        configure(32'h0800_0000, 4'd0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            en            = ($urandom_range(0, 3) != 0);
            cfg_valid     = ($urandom_range(0, 19) == 0);
            cfg_ftw       = $urandom;
            cfg_pow       = 4'($urandom_range(0, 15));
            cfg_phase_clr = 1'($urandom_range(0, 1));
            sweep_start   = ($urandom_range(0, 7) == 0);
            sweep_step    = $urandom >> $urandom_range(2, 8);
            sweep_stop    = $urandom;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
